// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_scoreboard_pkg
// Purpose : Shared pipeline constants and types for the ID-stage hazard
//           scoreboard and the EXE-stage forwarding unit.
// Contents: NUM_REGS / REG_W / CNT_W constants, register-index typedef,
//           hazard-mode encoding of forward_En.
// Revision: 1.0  initial release
// ============================================================================
package hazard_scoreboard_pkg;

  localparam int NUM_REGS = 16;  // architectural registers tracked
  localparam int REG_W    = 4;   // log2(NUM_REGS)
  localparam int CNT_W    = 2;   // per-register in-flight write counter width

  typedef logic [REG_W-1:0] reg_idx_t;

  // Meaning of forward_En, shared with the forwarding unit so both blocks
  // agree on which hazards the bypass network can cover.
  typedef enum logic {
    HZ_STALL_ALL = 1'b0,  // no bypass: any pending write stalls
    HZ_LOAD_USE  = 1'b1   // bypass on: only a load in EXE stalls
  } hz_mode_e;

endpackage : hazard_scoreboard_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module  : hazard_scoreboard_if
// Purpose : Bundle of ID-stage issue, WB-stage retire and status signals
//           between the pipeline control (master) and the scoreboard (slave).
// Ports   : master drives forward_En, src1/src2/use_src2, issue_*, retire_*;
//           slave drives hazard, pending_mask, err_overflow, err_underflow.
// Revision: 1.0  initial release
// ============================================================================
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = hazard_scoreboard_pkg::NUM_REGS
);

  logic                forward_En;
  reg_idx_t            src1;
  reg_idx_t            src2;
  logic                use_src2;
  logic                issue_valid;
  logic                issue_wbEn;
  logic                issue_memRead;
  reg_idx_t            issue_dest;
  logic                retire_wbEn;
  reg_idx_t            retire_dest;
  logic                hazard;
  logic [NUM_REGS-1:0] pending_mask;
  logic                err_overflow;
  logic                err_underflow;

  modport master (
    output forward_En, src1, src2, use_src2,
    output issue_valid, issue_wbEn, issue_memRead, issue_dest,
    output retire_wbEn, retire_dest,
    input  hazard, pending_mask, err_overflow, err_underflow
  );

  modport slave (
    input  forward_En, src1, src2, use_src2,
    input  issue_valid, issue_wbEn, issue_memRead, issue_dest,
    input  retire_wbEn, retire_dest,
    output hazard, pending_mask, err_overflow, err_underflow
  );

endinterface : hazard_scoreboard_if
`default_nettype wire

// File: rtl/hazard_scoreboard_pend_counter.sv
`default_nettype none
// ============================================================================
// Module  : pend_counter
// Purpose : Saturating up/down counter of in-flight writes to one register.
// Ports   : clk, rst (async active-low), inc, dec -> count,
//           err_ovf (inc onto saturated count), err_unf (dec onto zero).
//           Error outputs are single-cycle strobes; stickiness lives above.
// Revision: 1.0  initial release
// ============================================================================
module pend_counter #(
  parameter int CNT_W = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             inc,
  input  wire logic             dec,
  output logic      [CNT_W-1:0] count,
  output logic                  err_ovf,
  output logic                  err_unf
);

  localparam logic [CNT_W-1:0] C_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_ZERO = '0;

  // inc & dec together cancel: one write enters EXE as another leaves WB.
  logic up_only;
  logic dn_only;
  assign up_only = inc & ~dec;
  assign dn_only = dec & ~inc;

  assign err_ovf = up_only & (count == C_MAX);
  assign err_unf = dn_only & (count == C_ZERO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= C_ZERO;
    end else if (up_only && count != C_MAX) begin
      count <= count + 1'b1;
    end else if (dn_only && count != C_ZERO) begin
      count <= count - 1'b1;
    end
  end

endmodule : pend_counter
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : hazard_scoreboard
// Purpose : ID-stage scoreboard of register writes in flight (EXE/MEM/WB).
//           Requests a stall when an ID source cannot be supplied: load-use
//           only with forwarding on, any pending write with forwarding off.
// Ports   : clk, rst (async active-low), sb (hazard_scoreboard_if.slave):
//           issue/retire/source inputs in, hazard / pending_mask /
//           err_overflow / err_underflow out.
// Revision: 1.0  initial release
// ============================================================================
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = hazard_scoreboard_pkg::NUM_REGS,
  parameter int REG_W    = hazard_scoreboard_pkg::REG_W,
  parameter int CNT_W    = hazard_scoreboard_pkg::CNT_W
) (
  input wire logic       clk,
  input wire logic       rst,
  hazard_scoreboard_if.slave sb
);

  logic [CNT_W-1:0]    pend [NUM_REGS];
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] ovf;
  logic [NUM_REGS-1:0] unf;
  logic [NUM_REGS-1:0] nonzero;

  logic                issue_fire;
  logic                exe_load_valid;
  logic [REG_W-1:0]    exe_load_dest;
  logic                err_ovf_q;
  logic                err_unf_q;

  logic [REG_W-1:0]    s1;
  logic [REG_W-1:0]    s2;
  logic [CNT_W-1:0]    eff1;
  logic [CNT_W-1:0]    eff2;
  logic                hz_load_use;
  logic                hz_stall_all;
  hz_mode_e            mode;

  assign s1   = sb.src1;
  assign s2   = sb.src2;
  assign mode = hz_mode_e'(sb.forward_En);

  // hazard never depends on the issue inputs, so gating issue with it
  // forms no combinational loop.
  assign issue_fire = sb.issue_valid & sb.issue_wbEn & ~sb.hazard;

  generate
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
      assign inc[r]     = issue_fire  & (sb.issue_dest  == REG_W'(r));
      assign dec[r]     = sb.retire_wbEn & (sb.retire_dest == REG_W'(r));
      assign nonzero[r] = (pend[r] != '0);

      pend_counter #(
        .CNT_W (CNT_W)
      ) u_pend_counter (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc[r]),
        .dec     (dec[r]),
        .count   (pend[r]),
        .err_ovf (ovf[r]),
        .err_unf (unf[r])
      );
    end : g_pend
  endgenerate

  // The register file writes in WB while ID reads, so a write retiring this
  // cycle no longer blocks its reader: subtract it before testing for zero.
  always_comb begin
    eff1 = pend[s1] - CNT_W'(dec[s1]);
    eff2 = pend[s2] - CNT_W'(dec[s2]);
    hz_stall_all = (eff1 != '0) | (sb.use_src2 & (eff2 != '0));
    hz_load_use  = exe_load_valid &
                   ((exe_load_dest == s1) | (sb.use_src2 & (exe_load_dest == s2)));
  end

  // Held low during reset so a stall never leaks out of a resetting core.
  assign sb.hazard = rst & ((mode == HZ_LOAD_USE) ? hz_load_use : hz_stall_all);

  // A load occupies EXE for exactly one cycle after it issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_load_valid <= 1'b0;
      exe_load_dest  <= '0;
      err_ovf_q      <= 1'b0;
      err_unf_q      <= 1'b0;
    end else begin
      exe_load_valid <= issue_fire & sb.issue_memRead;
      exe_load_dest  <= sb.issue_dest;
      err_ovf_q      <= err_ovf_q | (|ovf);
      err_unf_q      <= err_unf_q | (|unf);
    end
  end

  assign sb.pending_mask  = nonzero;
  assign sb.err_overflow  = err_ovf_q;
  assign sb.err_underflow = err_unf_q;

endmodule : hazard_scoreboard
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side companion to the EXE-stage forwarding unit; sits in ID.
- Records every register write issued from ID (EXE/MEM/WB in flight) and retires it when WB writes the register file.
- Raises `hazard`, which freezes PC/IF-ID and inserts a bubble, whenever an ID source cannot be supplied:
  - forwarding on: load-use only;
  - forwarding off: any pending write.

Parameters:
- NUM_REGS, 16, architectural registers tracked.
- REG_W, 4, register index width (log2 NUM_REGS).
- CNT_W, 2, per-register pending-counter width (max 3 in flight).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- forward_En  in  1  forwarding enabled (same signal driving the forwarding unit).
- src1  in  REG_W  ID source register 1.
- src2  in  REG_W  ID source register 2.
- use_src2  in  1  ID instruction reads src2.
- issue_valid  in  1  ID instruction advances to EXE this cycle (already excludes branch flush).
- issue_wbEn  in  1  issuing instruction writes a register.
- issue_memRead  in  1  issuing instruction is a load.
- issue_dest  in  REG_W  issuing instruction's destination.
- retire_wbEn  in  1  WB stage writes register file this cycle.
- retire_dest  in  REG_W  WB destination.
- hazard  out  1  combinational stall request.
- pending_mask  out  NUM_REGS  bit r = 1 when pend[r] != 0 (registered view).
- err_overflow  out  1  sticky: issue onto a saturated counter.
- err_underflow  out  1  sticky: retire onto a zero counter.

Behaviour:
- State:
  - pend[NUM_REGS] counters, CNT_W bits each;
  - exe_load_valid (1 bit);
  - exe_load_dest (REG_W);
  - two sticky error flags.
- Reset (rst=0, asynchronous, any time including mid-stall):
  - all pend = 0, exe_load_valid = 0, exe_load_dest = 0, err_* = 0;
  - hence pending_mask = 0 and hazard = 0 while in reset.
- issue_fire = issue_valid & issue_wbEn & ~hazard. Issue with hazard=1 is ignored; no state change.
- Counter update per register r, same clock edge:
  - inc = issue_fire & (issue_dest == r);
  - dec = retire_wbEn & (retire_dest == r);
  - inc & dec: unchanged (simultaneous same-register issue/retire);
  - inc only: pend[r] at 3 stays 3 and err_overflow <= 1; else +1;
  - dec only: pend[r] at 0 stays 0 and err_underflow <= 1; else -1.
- Load tracking, next edge:
  - exe_load_valid <= issue_fire & issue_memRead;
  - exe_load_dest <= issue_dest;
  - holds the load for exactly its one EXE cycle; cleared the following cycle unless another load issues.
- Effective pending (combinational): eff[r] = pend[r] - (retire_wbEn & retire_dest == r).
  - The register file writes in WB the same cycle ID reads, so a retiring write is not a hazard.
- hazard, combinational from state and current inputs:
  - forward_En=1: hazard = exe_load_valid & ((exe_load_dest == src1) | (use_src2 & exe_load_dest == src2)).
  - forward_En=0: hazard = (eff[src1] != 0) | (use_src2 & eff[src2] != 0).
- forward_En may toggle any cycle; counters keep tracking regardless, so the hazard view is always consistent.
- Latency: issue visible in pending_mask one cycle after issue_fire; retire clears it one cycle after the WB cycle.
- Error flags never self-clear; only reset clears them.

Decomposition:
- Shared pipeline package holds:
  - REG_W / NUM_REGS constants;
  - register-index typedef;
  - hazard-mode encoding (forward_En meaning), shared with the forwarding unit.
- One natural sub-module: `pend_counter`, a single saturating up/down counter with inc/dec/err outputs, instantiated NUM_REGS times via generate.

Test Plan:
- Reset mid-operation: issue R3 (pend[3]=1), assert rst=0 between edges -> pending_mask=0 and hazard=0 immediately; flags 0 after release.
- forward_En=0 RAW: issue dest R2, next cycle src1=R2 -> hazard=1 for 2 cycles (EXE, MEM); in the retire cycle (retire_dest=R2) hazard=0, then pend[2]=0.
- forward_En=1 load-use: issue load dest R5, next cycle src2=R5, use_src2=1 -> hazard=1 one cycle only. Same with use_src2=0 -> hazard=0. Non-load dest R5 -> hazard=0.
- Simultaneous issue/retire R7 with pend[7]=1 -> pend[7] stays 1, pending_mask[7]=1, no error flag.
- Saturation: three back-to-back issues to R1 with no retire (pend=3), fourth issue -> pend stays 3, err_overflow=1 sticky. Retire to R9 at pend 0 -> err_underflow=1.
- Gated issue: hazard=1 with issue_valid=1, issue_dest=R4 -> pend[4] unchanged, exe_load_valid unchanged by that issue.
